// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
// The fetch stage is the master. imem_addr must stay stable while imem_req is high and no ack has arrived.
interface if_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC and fetches over a req/ack handshake.
// It drives the IF/ID register and supports freeze, branch redirect with flush,
// and variable-latency memory.
// A skid buffer catches a word that arrives while the stage is frozen.
// A discard state drains a fetch that became stale because of a redirect.
module if_stage #(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    if_stage_if.master          imem,
    input  logic                freeze,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_addr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [INSTR_W-1:0]  if_instr,
    output logic                if_valid
);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_HELD    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [INSTR_W-1:0] r_held_instr;
    logic [ADDR_W-1:0]  r_held_pc;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [INSTR_W-1:0] r_if_instr;
    logic               r_if_valid;

    logic [1:0]         w_state_next;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [ADDR_W-1:0]  w_req_addr_next;
    logic [INSTR_W-1:0] w_held_instr_next;
    logic [ADDR_W-1:0]  w_held_pc_next;
    logic [ADDR_W-1:0]  w_if_pc_next;
    logic [INSTR_W-1:0] w_if_instr_next;
    logic               w_if_valid_next;

    logic               w_req;
    logic               w_ack;
    logic [ADDR_W-1:0]  w_req_inc;

    // A request is outstanding in every state except HELD.
    // It is forced low while reset is asserted.
    assign w_req          = rst_n && (r_state != S_HELD);
    assign w_ack          = w_req && imem.imem_ack;
    assign w_req_inc      = r_req_addr + ADDR_W'(4);

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_req_addr;

    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;
    assign if_valid = r_if_valid;

    // Next-state logic. A redirect outranks freeze. Otherwise freeze holds the IF/ID register and the PC.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_req_addr_next   = r_req_addr;
        w_held_instr_next = r_held_instr;
        w_held_pc_next    = r_held_pc;
        w_if_pc_next      = r_if_pc;
        w_if_instr_next   = r_if_instr;
        w_if_valid_next   = r_if_valid;

        if (br_taken) begin
            // Flush IF/ID and retarget the PC. How the in-flight request is handled depends on the state.
            w_if_pc_next    = '0;
            w_if_instr_next = '0;
            w_if_valid_next = 1'b0;
            w_pc_next       = br_addr;
            case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        w_req_addr_next = br_addr;
                    end else begin
                        w_state_next = S_DISCARD;
                    end
                end
                S_HELD: begin
                    w_held_instr_next = '0;
                    w_held_pc_next    = '0;
                    w_req_addr_next   = br_addr;
                    w_state_next      = S_REQ;
                end
                default: begin
                    // Already discarding: the stale fetch keeps draining.
                    // pc takes the newest target.
                    w_state_next = S_DISCARD;
                end
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_ack && !freeze) begin
                        w_if_pc_next    = w_req_inc;
                        w_if_instr_next = imem.imem_rdata;
                        w_if_valid_next = 1'b1;
                        w_pc_next       = w_req_inc;
                        w_req_addr_next = w_req_inc;
                    end else if (w_ack) begin
                        w_held_instr_next = imem.imem_rdata;
                        w_held_pc_next    = w_req_inc;
                        w_state_next      = S_HELD;
                    end else if (!freeze) begin
                        w_if_pc_next    = '0;
                        w_if_instr_next = '0;
                        w_if_valid_next = 1'b0;
                    end
                end
                S_HELD: begin
                    if (!freeze) begin
                        w_if_pc_next    = r_held_pc;
                        w_if_instr_next = r_held_instr;
                        w_if_valid_next = 1'b1;
                        w_pc_next       = w_req_inc;
                        w_req_addr_next = w_req_inc;
                        w_state_next    = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (w_ack) begin
                        w_req_addr_next = r_pc;
                        w_state_next    = S_REQ;
                    end
                    if (!freeze) begin
                        w_if_pc_next    = '0;
                        w_if_instr_next = '0;
                        w_if_valid_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next = S_REQ;
                end
            endcase
        end
    end

    // State registers. Reset is asynchronous and abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_held_instr <= '0;
            r_held_pc    <= '0;
            r_if_pc      <= '0;
            r_if_instr   <= '0;
            r_if_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_req_addr   <= w_req_addr_next;
            r_held_instr <= w_held_instr_next;
            r_held_pc    <= w_held_pc_next;
            r_if_pc      <= w_if_pc_next;
            r_if_instr   <= w_if_instr_next;
            r_if_valid   <= w_if_valid_next;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage.
// The stimulus process pushes the expected program-order fetch stream into a queue.
// A branch restarts the stream at the target.
// A monitor process compares every IF/ID update against the queue and checks freeze holds, flushes, bubbles and address stability.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_addr = '0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    if_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    if_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem     (bus.master),
        .freeze   (freeze),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_valid (if_valid)
    );

    always #5 clk = ~clk;

    // Address-tagged memory content. It is distinct per address and effectively never zero.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    // Memory model. Latency counts the cycles a request is held, so 1 means zero-wait.
    // lat_mode 0 picks a random latency for each transaction.
    int lat_mode = 1;
    int rnd_lat  = 1;
    int wait_cnt = 0;
    int eff_lat;
    always_comb eff_lat = (lat_mode == 0) ? rnd_lat : lat_mode;
    assign bus.imem_ack   = bus.imem_req && (wait_cnt >= eff_lat - 1);
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (bus.imem_req && bus.imem_ack) begin
            wait_cnt <= 0;
            rnd_lat  <= $urandom_range(1, 4);
        end else if (bus.imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Check bookkeeping.
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference stream: the fetch addresses expected to appear as valid IF/ID entries, in order.
    logic [31:0] exp_q[$];
    logic [31:0] next_addr;

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_addr);
            next_addr = next_addr + 32'd4;
        end
    endtask

    task automatic sb_reset(input logic [31:0] a);
        exp_q.delete();
        next_addr = a;
        top_up();
    endtask

    task automatic tick();
        @(negedge clk);
        top_up();
    endtask

    // Monitor.
    bit mon_en     = 1'b0;
    bit lat_chk_en = 1'b0;
    int phase      = 0;
    int n_valid    = 0;

    initial begin
        bit          p_en, p_freeze, p_br, p_req, p_ack, p_latchk, seen;
        logic [31:0] p_addr, p_pc, p_instr, e;
        logic        p_valid;
        int          p_phase, p_exp_bub, bub_run, seen_phase;
        seen = 1'b0; bub_run = 0; seen_phase = -1;
        forever begin
            @(negedge clk); #3;
            p_en      = mon_en && rst_n;
            p_freeze  = freeze;
            p_br      = br_taken;
            p_req     = bus.imem_req;
            p_ack     = bus.imem_req && bus.imem_ack;
            p_addr    = bus.imem_addr;
            p_pc      = if_pc;
            p_instr   = if_instr;
            p_valid   = if_valid;
            p_phase   = phase;
            p_latchk  = lat_chk_en;
            p_exp_bub = lat_mode - 1;
            @(posedge clk); #1;
            if (p_en && mon_en && rst_n) begin
                if (p_req && !p_ack)
                    chk("addr_stable", bus.imem_req && bus.imem_addr == p_addr,
                        {31'd0, bus.imem_req, bus.imem_addr}, {32'd1, p_addr});
                if (p_br) begin
                    chk("flush", if_pc == 0 && if_instr == 0 && !if_valid,
                        {if_pc, if_instr}, 64'd0);
                    seen = 1'b0;
                end else if (p_freeze) begin
                    chk("freeze_hold", if_pc == p_pc && if_instr == p_instr && if_valid == p_valid,
                        {if_pc, if_instr}, {p_pc, p_instr});
                    seen = 1'b0;
                end else if (if_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 1'b0, {if_pc, if_instr}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fetch", if_pc == e + 32'd4 && if_instr == mem_word(e),
                            {if_pc, if_instr}, {e + 32'd4, mem_word(e)});
                    end
                    n_valid++;
                    if (p_latchk && seen && seen_phase == p_phase)
                        chk("bubbles", bub_run == p_exp_bub, 64'(bub_run), 64'(p_exp_bub));
                    seen = 1'b1;
                    seen_phase = p_phase;
                    bub_run = 0;
                end else begin
                    chk("bubble", if_pc == 0 && if_instr == 0, {if_pc, if_instr}, 64'd0);
                    bub_run++;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Stimulus.
    initial begin
        bit found;
        int v0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_if_pc", if_pc == 0, 64'(if_pc), 64'd0);
        chk("rst_if_instr", if_instr == 0, 64'(if_instr), 64'd0);
        chk("rst_if_valid", !if_valid, 64'(if_valid), 64'd0);
        chk("rst_imem_req", !bus.imem_req, 64'(bus.imem_req), 64'd0);

        sb_reset(RST_PC);
        rst_n = 1'b1;
        #1;
        chk("req_after_rst", bus.imem_req && bus.imem_addr == RST_PC,
            {31'd0, bus.imem_req, bus.imem_addr}, {32'd1, RST_PC});
        mon_en = 1'b1;

        // Zero-wait streaming, wrapping through 0.
        phase = 1; lat_mode = 1; lat_chk_en = 1'b1;
        repeat (10) tick();
        // Latency 3: two bubbles per instruction.
        phase = 2; lat_mode = 3;
        repeat (15) tick();
        lat_chk_en = 1'b0;

        // Freeze for two cycles while the word for 0x10 is acknowledged.
        phase = 3; lat_mode = 1;
        br_taken = 1'b1; br_addr = 32'h0; sb_reset(32'h0);
        tick();
        br_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.imem_req && bus.imem_ack && bus.imem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("find_0x10", found, 64'(found), 64'd1);
        if (found) begin
            freeze = 1'b1;
            tick();
            chk("held_req0", !bus.imem_req, 64'(bus.imem_req), 64'd0);
            tick();
            chk("held_req1", !bus.imem_req, 64'(bus.imem_req), 64'd0);
            freeze = 1'b0;
            tick();
            chk("unfreeze_pc", if_pc == 32'h14 && if_valid, {31'd0, if_valid, if_pc}, {32'd1, 32'h14});
            chk("unfreeze_instr", if_instr == mem_word(32'h10), 64'(if_instr), 64'(mem_word(32'h10)));
            chk("next_fetch", bus.imem_req && bus.imem_addr == 32'h14,
                {31'd0, bus.imem_req, bus.imem_addr}, {32'd1, 32'h14});
        end

        // Branch to 0x40 one cycle before a latency-3 ack.
        phase = 4; lat_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req && wait_cnt == 1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("find_wait", found, 64'(found), 64'd1);
        br_taken = 1'b1; br_addr = 32'h40; sb_reset(32'h40);
        tick();
        br_taken = 1'b0;
        repeat (10) tick();

        // Branch while frozen in the skid-buffer state.
        phase = 5; lat_mode = 1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req && bus.imem_ack) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("find_ack", found, 64'(found), 64'd1);
        freeze = 1'b1;
        tick();
        chk("held_enter", !bus.imem_req, 64'(bus.imem_req), 64'd0);
        br_taken = 1'b1; br_addr = 32'h80; sb_reset(32'h80);
        tick();
        br_taken = 1'b0; freeze = 1'b0;
        chk("held_flush", if_pc == 0 && if_instr == 0 && !if_valid, {if_pc, if_instr}, 64'd0);
        chk("held_redirect", bus.imem_req && bus.imem_addr == 32'h80,
            {31'd0, bus.imem_req, bus.imem_addr}, {32'd1, 32'h80});
        repeat (5) tick();

        // Random freeze, branches and latency.
        phase = 6; lat_mode = 0;
        v0 = n_valid;
        for (int i = 0; i < 400; i++) begin
            freeze   = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 19) == 0);
            if (br_taken) begin
                br_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_03FC);
                sb_reset(br_addr);
            end
            tick();
        end
        freeze = 1'b0; br_taken = 1'b0;
        repeat (20) tick();
        chk("progress", (n_valid - v0) > 20, 64'(n_valid - v0), 64'd21);

        // Asynchronous reset mid-wait while IF/ID holds a valid instruction.
        phase = 7; lat_mode = 2;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid && bus.imem_req && !bus.imem_ack) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("find_midwait", found, 64'(found), 64'd1);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst", if_pc == 0 && if_instr == 0 && !if_valid && !bus.imem_req,
            {if_pc[30:0], bus.imem_req, if_instr}, 64'd0);
        tick(); tick();
        sb_reset(RST_PC);
        lat_mode = 1; phase = 8; lat_chk_en = 1'b1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (8) tick();
        lat_chk_en = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
